fifo_write_arbiter: RTL and testbench

Write-side controller for the async FIFO dual-port memory, running entirely in the write clock domain. It shares the single memory write port between num_req requesters using round-robin arbitration. It owns the write pointer (binary and Gray), synchronises the read-domain Gray pointer, and generates full and almost_full. Its memory-side outputs connect directly to the memory write port; its Gray pointer goes to the read-side controller.

---
 rtl/fifo_write_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Async FIFO write side: round-robin write-port arbiter,
// write pointer owner, read-pointer sync, full/almost_full.
//
// Ports:
//   write_clk, rst       clock, async active-high reset
//   req, req_data        per-requester request and word
//   grant                one-hot combinational grant
//   wr, write_address,
//   write_data           memory write port
//   rptr_gray_async      read pointer (Gray) from read domain
//   wptr_gray            registered write pointer (Gray)
//   full, almost_full    registered flags
module fifo_write_arbiter #(
  parameter int data_width        = 32,
  parameter int address_width     = 4,
  parameter int num_req           = 4,
  parameter int almost_full_level = 12
) (
  input  logic                          write_clk,
  input  logic                          rst,
  input  logic [num_req-1:0]            req,
  input  logic [num_req*data_width-1:0] req_data,
  output logic [num_req-1:0]            grant,
  output logic                          wr,
  output logic [address_width-1:0]      write_address,
  output logic [data_width-1:0]         write_data,
  input  logic [address_width:0]        rptr_gray_async,
  output logic [address_width:0]        wptr_gray,
  output logic                          full,
  output logic                          almost_full
);

  localparam int PW = address_width + 1;
  localparam int IW = $clog2(num_req);

  logic [PW-1:0] wptr_bin;
  logic [PW-1:0] wptr_bin_next;
  logic [PW-1:0] wptr_gray_next;
  logic [PW-1:0] rsync1;
  logic [PW-1:0] rsync2;
  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] occupancy;
  logic [PW-1:0] full_match;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] win_idx;
  logic          win_vld;
  logic          full_next;
  logic          af_next;

  function automatic logic [PW-1:0] gray2bin(
    input logic [PW-1:0] g
  );
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Scan from the requester after the last winner, wrapping.
  always_comb begin : arb
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= num_req; k++) begin
      idx = (int'(last_grant) + k) % num_req;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    grant      = '0;
    write_data = '0;
    if (!rst && !full && win_vld) begin
      grant[win_idx] = 1'b1;
      write_data =
        req_data[win_idx*data_width +: data_width];
    end
  end

  assign wr            = |grant;
  assign write_address = wptr_bin[address_width-1:0];

  assign wptr_bin_next  = wptr_bin + PW'(wr);
  assign wptr_gray_next =
    wptr_bin_next ^ (wptr_bin_next >> 1);

  // Full when write is one lap ahead of the synced read:
  // in Gray code that is the top two bits inverted.
  assign full_match = {~rsync2[PW-1:PW-2], rsync2[PW-3:0]};
  assign full_next  = (wptr_gray_next == full_match);

  assign rptr_bin  = gray2bin(rsync2);
  assign occupancy = wptr_bin_next - rptr_bin;
  assign af_next   = 32'(occupancy) >= almost_full_level;

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      wptr_bin    <= '0;
      wptr_gray   <= '0;
      rsync1      <= '0;
      rsync2      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      last_grant  <= IW'(num_req - 1);
    end else begin
      rsync1      <= rptr_gray_async;
      rsync2      <= rsync1;
      wptr_bin    <= wptr_bin_next;
      wptr_gray   <= wptr_gray_next;
      full        <= full_next;
      almost_full <= af_next;
      if (wr)
        last_grant <= win_idx;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter.
// Directed scenarios plus randomized traffic vs a model.
module tb_fifo_write_arbiter;

  logic         write_clk = 1'b0;
  logic         rst       = 1'b1;
  logic [3:0]   req       = '0;
  logic [127:0] req_data  = '0;
  logic [3:0]   grant;
  logic         wr;
  logic [3:0]   write_address;
  logic [31:0]  write_data;
  logic [4:0]   rptr_gray_async = '0;
  logic [4:0]   wptr_gray;
  logic         full;
  logic         almost_full;

  int checks = 0;
  int passes = 0;

  // model: total writes, read pointer (binary),
  // two-stage view of the read pointer, last winner
  int m_w, m_rd, m_s1, m_s2, m_last;
  bit m_full, m_af;

  logic [31:0] tb_mem [16];

  fifo_write_arbiter dut (
    .write_clk       (write_clk),
    .rst             (rst),
    .req             (req),
    .req_data        (req_data),
    .grant           (grant),
    .wr              (wr),
    .write_address   (write_address),
    .write_data      (write_data),
    .rptr_gray_async (rptr_gray_async),
    .wptr_gray       (wptr_gray),
    .full            (full),
    .almost_full     (almost_full)
  );

  always #5 write_clk = ~write_clk;

  always @(posedge write_clk)
    if (wr) tb_mem[write_address] <= write_data;

  function automatic logic [4:0] gray(int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int pick(logic [3:0] r);
    if (m_full) return -1;
    for (int k = 1; k <= 4; k++)
      if (r[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction

  task automatic set_rd(int v);
    m_rd = v;
    rptr_gray_async = gray(v);
  endtask

  task automatic set_data(int i, logic [31:0] v);
    req_data[i*32 +: 32] = v;
  endtask

  task automatic model_reset();
    m_w = 0; m_rd = 0; m_s1 = 0; m_s2 = 0;
    m_last = 3; m_full = 0; m_af = 0;
  endtask

  // one clock edge; model follows the flag rules
  task automatic clk_edge();
    int win, occ;
    win = pick(req);
    @(posedge write_clk);
    if (win >= 0) begin
      m_w++;
      m_last = win;
    end
    occ = m_w - m_s2;
    m_full = (occ == 16);
    m_af = (occ >= 12);
    m_s2 = m_s1;
    m_s1 = m_rd;
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    req = '0;
    set_rd(0);
    model_reset();
    repeat (2) @(posedge write_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    req = 4'b0001;
    set_data(0, 32'hA5A5_0001);
    repeat (5) clk_edge();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0) $display("FAIL rst_grant got %b exp 0", grant);
    else passes++;
    checks++;
    if (wr !== 1'b0) $display("FAIL rst_wr got %b exp 0", wr);
    else passes++;
    checks++;
    if (write_address !== 4'd0)
      $display("FAIL rst_addr got %0d exp 0", write_address);
    else passes++;
    checks++;
    if (wptr_gray !== 5'd0)
      $display("FAIL rst_wptr got %b exp 0", wptr_gray);
    else passes++;
    checks++;
    if (full !== 1'b0 || almost_full !== 1'b0)
      $display("FAIL rst_flags got %b%b exp 00", full, almost_full);
    else passes++;
    checks++;
    if (write_data !== 32'd0)
      $display("FAIL rst_data got %h exp 0", write_data);
    else passes++;
    req = '0;
    model_reset();
    repeat (2) @(posedge write_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_fill();
    logic [31:0] d [16];
    do_reset();
    req = 4'b0001;
    for (int n = 0; n < 16; n++) begin
      d[n] = $urandom;
      set_data(0, d[n]);
      #1;
      checks++;
      if (grant !== 4'b0001 || write_address !== 4'(n) ||
          write_data !== d[n])
        $display("FAIL fill_acc%0d got g=%b a=%0d d=%h exp g=0001 a=%0d d=%h",
                 n, grant, write_address, write_data, n, d[n]);
      else passes++;
      clk_edge();
      checks++;
      if (almost_full !== (n + 1 >= 12) || full !== (n + 1 == 16))
        $display("FAIL fill_flags%0d got af=%b f=%b exp af=%b f=%b",
                 n, almost_full, full, n + 1 >= 12, n + 1 == 16);
      else passes++;
    end
    for (int k = 0; k < 3; k++) begin
      set_data(0, $urandom);
      #1;
      checks++;
      if (grant !== 4'b0 || wr !== 1'b0)
        $display("FAIL fill_blocked got g=%b wr=%b exp 0 0", grant, wr);
      else passes++;
      clk_edge();
      checks++;
      if (full !== 1'b1) $display("FAIL fill_hold got f=%b exp 1", full);
      else passes++;
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (tb_mem[i] !== d[i])
        $display("FAIL fill_mem%0d got %h exp %h", i, tb_mem[i], d[i]);
      else passes++;
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] d [4];
    int seq1 [6] = '{0, 1, 2, 3, 0, 1};
    int seq2 [5] = '{3, 1, 3, 1, 3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      set_data(i, d[i]);
    end
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (grant !== 4'(1 << seq1[k]) || write_data !== d[seq1[k]])
        $display("FAIL rr_all%0d got g=%b d=%h exp g=%b d=%h", k,
                 grant, write_data, 4'(1 << seq1[k]), d[seq1[k]]);
      else passes++;
      clk_edge();
    end
    req = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (grant !== 4'(1 << seq2[k]))
        $display("FAIL rr_odd%0d got %b exp %b", k,
                 grant, 4'(1 << seq2[k]));
      else passes++;
      clk_edge();
    end
    #1;
    checks++;
    if (grant !== 4'b0010)
      $display("FAIL rr_pre_drop got %b exp 0010", grant);
    else passes++;
    clk_edge();
    req = 4'b0010;
    #1;
    checks++;
    if (grant !== 4'b0010)
      $display("FAIL rr_drop got %b exp 0010", grant);
    else passes++;
    clk_edge();
  endtask

  task automatic test_full_release();
    do_reset();
    req = 4'b0001;
    repeat (16) clk_edge();
    checks++;
    if (full !== 1'b1) $display("FAIL rel_full got %b exp 1", full);
    else passes++;
    set_rd(1);
    for (int e = 1; e <= 3; e++) begin
      #1;
      checks++;
      if (grant !== 4'b0)
        $display("FAIL rel_gnt%0d got %b exp 0", e, grant);
      else passes++;
      clk_edge();
      checks++;
      if (full !== (e < 3))
        $display("FAIL rel_edge%0d got f=%b exp %b", e, full, e < 3);
      else passes++;
    end
    #1;
    checks++;
    if (grant !== 4'b0001 || write_address !== 4'd0)
      $display("FAIL rel_next got g=%b a=%0d exp g=0001 a=0",
               grant, write_address);
    else passes++;
    clk_edge();
    checks++;
    if (full !== 1'b1)
      $display("FAIL rel_refill got f=%b exp 1", full);
    else passes++;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0001;
    repeat (16) clk_edge();
    req = '0;
    set_rd(16);
    repeat (3) clk_edge();
    checks++;
    if (full !== 1'b0 || almost_full !== 1'b0)
      $display("FAIL wrap_empty got f=%b af=%b exp 0 0",
               full, almost_full);
    else passes++;
    req = 4'b0001;
    #1;
    checks++;
    if (grant !== 4'b0001 || write_address !== 4'd0)
      $display("FAIL wrap_addr got g=%b a=%0d exp g=0001 a=0",
               grant, write_address);
    else passes++;
    clk_edge();
    req = '0;
    checks++;
    if (wptr_gray !== 5'b11001)
      $display("FAIL wrap_gray got %b exp 11001", wptr_gray);
    else passes++;
    checks++;
    if (full !== 1'b0 || almost_full !== 1'b0)
      $display("FAIL wrap_flags got f=%b af=%b exp 0 0",
               full, almost_full);
    else passes++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 4'b0001;
    repeat (15) clk_edge();
    req = '0;
    checks++;
    if (full !== 1'b0 || almost_full !== 1'b1)
      $display("FAIL sim_15 got f=%b af=%b exp 0 1", full, almost_full);
    else passes++;
    set_rd(1);
    // accept lands on the edge where the synced read advances
    repeat (2) clk_edge();
    req = 4'b0001;
    #1;
    checks++;
    if (grant !== 4'b0001)
      $display("FAIL sim_gnt got %b exp 0001", grant);
    else passes++;
    clk_edge();
    req = '0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (full !== 1'b0 || almost_full !== 1'b1)
        $display("FAIL sim_settle%0d got f=%b af=%b exp 0 1",
                 k, full, almost_full);
      else passes++;
      clk_edge();
    end
  endtask

  task automatic test_random();
    logic [3:0]  pend;
    logic [31:0] d [4];
    logic [3:0]  eg;
    int e;
    do_reset();
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          d[i] = $urandom;
          set_data(i, d[i]);
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      req = pend;
      if (m_rd < m_w && $urandom_range(0, 2) == 0)
        set_rd(m_rd + 1);
      #1;
      e = pick(req);
      eg = (e < 0) ? 4'b0 : 4'(1 << e);
      checks++;
      if (grant !== eg || wr !== (e >= 0))
        $display("FAIL rnd_gnt c%0d got g=%b wr=%b exp g=%b wr=%b",
                 c, grant, wr, eg, e >= 0);
      else passes++;
      checks++;
      if (write_address !== m_w[3:0] ||
          write_data !== ((e < 0) ? 32'd0 : d[e]))
        $display("FAIL rnd_port c%0d got a=%0d d=%h exp a=%0d d=%h",
                 c, write_address, write_data, m_w[3:0],
                 (e < 0) ? 32'd0 : d[e]);
      else passes++;
      clk_edge();
      if (e >= 0) pend[e] = 1'b0;
      checks++;
      if (wptr_gray !== gray(m_w) || full !== m_full ||
          almost_full !== m_af)
        $display("FAIL rnd_state c%0d got g=%b f=%b af=%b exp g=%b f=%b af=%b",
                 c, wptr_gray, full, almost_full,
                 gray(m_w), m_full, m_af);
      else passes++;
    end
    req = '0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge write_clk);
    #1;
    test_reset();
    test_single_fill();
    test_round_robin();
    test_full_release();
    test_wrap();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
